// File: rtl/mem_responder.sv
// mem_responder: word-addressed data memory behind a valid/ready
// load/store port, with configurable wait states before each access.
module mem_responder #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              err;
  logic              accept;
  logic              mem_we;

  assign idx       = addr_q[ADDR_W+1:2];
  assign err       = (addr_q[1:0] != 2'b00) | (|addr_q[31:ADDR_W+2]);
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid & req_ready;
  assign mem_we    = (state == S_ACCESS) & wr_q & ~err;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (req_valid)
          state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:
        if (cnt == 4'd0)
          state_nxt = S_ACCESS;
      S_ACCESS:
        state_nxt = S_RESP;
      S_RESP:
        if (rsp_ready)
          state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(CNT_INIT);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // response is captured once and held through backpressure
      if (state == S_ACCESS) begin
        rsp_err   <= err;
        rsp_rdata <= (err | wr_q) ? 32'd0 : mem[idx];
      end
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for two responder
// instances, one with the default wait states and one with none.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_req_valid = 1'b0;
  logic        a_req_write = 1'b0;
  logic [31:0] a_req_addr = 32'd0;
  logic [31:0] a_req_wdata = 32'd0;
  logic        a_req_ready;
  logic        a_rsp_valid;
  logic        a_rsp_ready = 1'b0;
  logic [31:0] a_rsp_rdata;
  logic        a_rsp_err;

  logic        b_req_valid = 1'b0;
  logic        b_req_write = 1'b0;
  logic [31:0] b_req_addr = 32'd0;
  logic [31:0] b_req_wdata = 32'd0;
  logic        b_req_ready;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b0;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_ready (a_req_ready),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  mem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_ready (b_req_ready),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel) begin
      b_req_valid = v;
      b_req_write = wr;
      b_req_addr  = addr;
      b_req_wdata = wd;
    end else begin
      a_req_valid = v;
      a_req_write = wr;
      a_req_addr  = addr;
      a_req_wdata = wd;
    end
  endtask

  task automatic pop_check(input bit sel);
    exp_t e;
    chk("sb_pending", 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("rsp_rdata", sel ? b_rsp_rdata : a_rsp_rdata, e.rdata);
      chk("rsp_err", {31'd0, sel ? b_rsp_err : a_rsp_err}, {31'd0, e.err});
    end
  endtask

  task automatic do_req(input bit sel, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   lat;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sbq.push_back(e);
    drive(sel, 1'b1, wr, addr, wd);
    chk("req_ready", {31'd0, sel ? b_req_ready : a_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    lat = 0;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), sel ? 32'd1 : 32'd3);
    pop_check(sel);
    if (sel) b_rsp_ready = 1'b1;
    else     a_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    b_rsp_ready = 1'b0;
    a_rsp_ready = 1'b0;
    chk("idle_ready", {31'd0, sel ? b_req_ready : a_req_ready}, 32'd1);
    chk("idle_valid", {31'd0, sel ? b_rsp_valid : a_rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   w;
    int   t[4];

    // power-on reset
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);

    // store then load
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    do_req(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // error cases
    do_req(1'b0, 1'b1, 32'h12, 32'h0BADF00D, 32'd0, 1'b1);
    do_req(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 1'b0, 32'h100, 32'd0, 32'd0, 1'b1);

    // reset mid-WAIT abandons the store
    do_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    do_req(1'b0, 1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h11112222);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("mid_wait_ready", {31'd0, a_req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("async_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("async_rsp_rdata", a_rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rel_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rel_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rel_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rel_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    do_req(1'b0, 1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);

    // backpressure in RESP
    e.rdata = 32'hDEADBEEF;
    e.err   = 1'b0;
    sbq.push_back(e);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    @(posedge clk);
    #1;
    w = 0;
    while (!a_rsp_valid && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    pop_check(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
      chk("bp_rsp_err", {31'd0, a_rsp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    a_rsp_ready = 1'b0;
    chk("bp_release_ready", {31'd0, a_req_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, a_rsp_valid}, 32'd0);

    // back-to-back stores with rsp_ready tied high
    a_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'(i * 4), 32'hA5000000 + 32'(i));
      e.rdata = 32'd0;
      e.err   = 1'b0;
      sbq.push_back(e);
      w = 0;
      while (!a_req_ready && w < 40) begin
        @(posedge clk);
        #1;
        w++;
        if (a_rsp_valid) pop_check(1'b0);
      end
      @(posedge clk);
      #1;
      t[i] = cyc;
      if (i > 0) chk("b2b_gap", 32'(t[i] - t[i-1]), 32'd5);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    w = 0;
    while (sbq.size() != 0 && w < 40) begin
      @(posedge clk);
      #1;
      w++;
      if (a_rsp_valid) pop_check(1'b0);
    end
    chk("b2b_drained", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b0;
    chk("b2b_idle", {31'd0, a_req_ready}, 32'd1);
    for (int i = 0; i < 4; i++)
      do_req(1'b0, 1'b0, 32'(i * 4), 32'd0, 32'hA5000000 + 32'(i), 1'b0);

    // zero wait states
    do_req(1'b1, 1'b1, 32'h4, 32'h12345678, 32'd0, 1'b0);
    do_req(1'b1, 1'b0, 32'h4, 32'd0, 32'h12345678, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data-memory responder serving the processor core's load/store port over a valid/ready request and response handshake. It accepts one request at a time and inserts a configurable number of wait states. It performs the 32-bit read or write, then holds the response until the core takes it. It sits between the core's memory-access stage (MemWrite, ALU address, WriteData) and the result mux feeding MemtoReg.

## Interface
Parameters:
- ADDR_W, 6: word-address width; storage depth 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and memory access; legal range 0–15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; low clears all control state immediately.
- req_valid  input  1  core presents a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- rsp_valid  output  1  response available; high only in RESP.
- rsp_ready  input  1  core consumes response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch req_write, req_addr and req_wdata.
  - Next state is WAIT when WAIT_CYCLES>0; otherwise ACCESS.
  - WAIT counter loads WAIT_CYCLES-1.
- WAIT: counter decrements each cycle. At counter==0, go to ACCESS. Request inputs are ignored.
- ACCESS: one cycle. Error check on the latched address:
  - err = (addr[1:0]!=0) | (addr[31:ADDR_W+2]!=0).
  - No error, store: mem[addr[ADDR_W+1:2]] <= wdata; rsp_rdata <= 0.
  - No error, load: rsp_rdata <= mem[index].
  - Error: no write; rsp_rdata <= 0; rsp_err <= 1.
  - Always go to RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err stay stable. When rsp_ready is high, go to IDLE. Otherwise hold indefinitely.
- Only one outstanding request; no request is accepted in WAIT, ACCESS or RESP.
- Memory array is not reset; reading a never-written word returns undefined data.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.

## Timing
- Accept edge E0 = first rising edge with req_valid=1 and req_ready=1.
- The memory write commits at edge E0+WAIT_CYCLES+1, i.e. the ACCESS→RESP edge.
- rsp_valid rises after edge E0+WAIT_CYCLES+1, so it is visible WAIT_CYCLES+1 cycles after acceptance.
- Response handshake completes on the first edge with rsp_valid=1 and rsp_ready=1. req_ready returns high in the following cycle.
- With rsp_ready tied high, throughput is one transaction per WAIT_CYCLES+3 cycles.
- Simultaneous req_valid and rsp_ready in RESP: the request is not accepted. The core must hold req_valid until req_ready is seen.
- Reset asserted mid-transaction:
  - The transaction is abandoned and outputs return to reset values asynchronously.
  - If reset asserts before the ACCESS→RESP edge, no write occurs.
  - Memory contents written earlier are retained.
- Load-after-store to the same address always returns the new data, because operations are serialized.

## Test plan
- Reset: hold reset low for 3 cycles mid-WAIT, then release → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; no memory write occurred.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x10 → rsp_valid high 3 cycles after accept, rsp_err=0, rsp_rdata=0.
  - Load 0x10 → rsp_rdata=0xDEADBEEF.
- WAIT_CYCLES=0: load of address 0x4 (previously written 0x12345678) → rsp_valid high 1 cycle after accept, rsp_rdata=0x12345678.
- Errors, with ADDR_W=6:
  - Store to 0x12 (misaligned) → rsp_err=1; address 0x10 still reads its prior value.
  - Load 0x100 (out of range) → rsp_err=1, rsp_rdata=0.
- Backpressure: hold rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stable; req_ready stays 0 even with req_valid=1. Raise rsp_ready → IDLE next cycle.
- Back-to-back: rsp_ready tied 1, req_valid held 1 with 4 stores to 0x0, 0x4, 0x8, 0xC → accepts spaced exactly WAIT_CYCLES+3 cycles apart; readback returns all 4 values.
